// File: rtl/microwave_ctrl.sv
// Microwave oven sequencer: keypad MM:SS entry, timer start/pause/stop pulses,
// magnetron/lamp/beeper drive with a door interlock on heating.
module microwave_ctrl #(
    parameter int BEEP_CYCLES = 100_000_000,
    parameter int QUICK_SEC   = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       door_open,
    input  logic       timer_done,
    output logic [6:0] tmr_min,
    output logic [6:0] tmr_sec,
    output logic       tmr_start,
    output logic       tmr_pause,
    output logic       tmr_stop,
    output logic       magnetron_on,
    output logic       lamp_on,
    output logic       beep,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_COOK   = 3'd2,
        S_PAUSED = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [15:0] QUICK_BUF = {8'h00, 4'(QUICK_SEC / 10), 4'(QUICK_SEC % 10)};
    localparam logic [26:0] BEEP_LAST = 27'(BEEP_CYCLES - 1);

    state_t      state_r;
    state_t      nxt_state_s;
    logic [15:0] buf_r;
    logic [15:0] nxt_buf_s;
    logic [26:0] beep_cnt_r;
    logic [26:0] nxt_cnt_s;
    logic        start_s;
    logic        pause_s;
    logic        stop_s;
    logic        is_digit_s;
    logic        is_start_s;
    logic        is_pause_s;
    logic        is_clear_s;

    function automatic logic [6:0] bcd2bin(input logic [3:0] hi, input logic [3:0] lo);
        return 7'(hi) * 7'd10 + 7'(lo);
    endfunction

    function automatic logic [6:0] sec_clip(input logic [6:0] sec);
        return (sec > 7'd59) ? 7'd59 : sec;
    endfunction

    assign is_digit_s = key_valid && (key_code <= 4'd9);
    assign is_start_s = key_valid && (key_code == 4'hA);
    assign is_pause_s = key_valid && (key_code == 4'hB);
    assign is_clear_s = key_valid && (key_code == 4'hC);

    // Next-state, digit buffer and pulse decode; CLEAR > timer_done > door > START/PAUSE
    always_comb begin
        nxt_state_s = state_r;
        nxt_buf_s   = buf_r;
        nxt_cnt_s   = beep_cnt_r;
        start_s     = 1'b0;
        pause_s     = 1'b0;
        stop_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (is_digit_s) begin
                    nxt_buf_s   = {12'h000, key_code};
                    nxt_state_s = S_ENTRY;
                end else if (is_start_s && !door_open) begin
                    nxt_buf_s   = QUICK_BUF;
                    start_s     = 1'b1;
                    nxt_state_s = S_COOK;
                end else begin
                    nxt_state_s = S_IDLE;
                end
            end
            S_ENTRY: begin
                if (is_clear_s) begin
                    nxt_buf_s   = 16'h0000;
                    nxt_state_s = S_IDLE;
                end else if (is_digit_s) begin
                    nxt_buf_s = {buf_r[11:0], key_code};
                end else if (is_start_s && !door_open && (buf_r != 16'h0000)) begin
                    start_s     = 1'b1;
                    nxt_state_s = S_COOK;
                end else begin
                    nxt_state_s = S_ENTRY;
                end
            end
            S_COOK: begin
                if (is_clear_s) begin
                    stop_s      = 1'b1;
                    nxt_buf_s   = 16'h0000;
                    nxt_state_s = S_IDLE;
                end else if (timer_done) begin
                    nxt_cnt_s   = 27'd0;
                    nxt_state_s = S_DONE;
                end else if (door_open || is_pause_s) begin
                    pause_s     = 1'b1;
                    nxt_state_s = S_PAUSED;
                end else begin
                    nxt_state_s = S_COOK;
                end
            end
            S_PAUSED: begin
                if (is_clear_s) begin
                    stop_s      = 1'b1;
                    nxt_buf_s   = 16'h0000;
                    nxt_state_s = S_IDLE;
                end else if (is_start_s && !door_open) begin
                    start_s     = 1'b1;
                    nxt_state_s = S_COOK;
                end else begin
                    nxt_state_s = S_PAUSED;
                end
            end
            S_DONE: begin
                if (key_valid || (beep_cnt_r == BEEP_LAST)) begin
                    nxt_buf_s   = 16'h0000;
                    nxt_state_s = S_IDLE;
                end else begin
                    nxt_cnt_s = beep_cnt_r + 27'd1;
                end
            end
            default: begin
                nxt_state_s = S_IDLE;
            end
        endcase
    end

    // State, buffer and all registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= S_IDLE;
            buf_r        <= 16'h0000;
            beep_cnt_r   <= 27'd0;
            tmr_min      <= 7'd0;
            tmr_sec      <= 7'd0;
            tmr_start    <= 1'b0;
            tmr_pause    <= 1'b0;
            tmr_stop     <= 1'b0;
            magnetron_on <= 1'b0;
            lamp_on      <= 1'b0;
            beep         <= 1'b0;
        end else begin
            state_r      <= nxt_state_s;
            buf_r        <= nxt_buf_s;
            beep_cnt_r   <= nxt_cnt_s;
            tmr_min      <= bcd2bin(nxt_buf_s[15:12], nxt_buf_s[11:8]);
            tmr_sec      <= sec_clip(bcd2bin(nxt_buf_s[7:4], nxt_buf_s[3:0]));
            tmr_start    <= start_s;
            tmr_pause    <= pause_s;
            tmr_stop     <= stop_s;
            magnetron_on <= (nxt_state_s == S_COOK);
            lamp_on      <= (nxt_state_s == S_COOK) || (nxt_state_s == S_PAUSED) || door_open;
            beep         <= (nxt_state_s == S_DONE);
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Scoreboard bench for microwave_ctrl with a short beep interval.
module tb_microwave_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       door_open;
    logic       timer_done;
    logic [6:0] tmr_min;
    logic [6:0] tmr_sec;
    logic       tmr_start;
    logic       tmr_pause;
    logic       tmr_stop;
    logic       magnetron_on;
    logic       lamp_on;
    logic       beep;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [2:0] st;
        logic [6:0] mn;
        logic [6:0] sc;
        logic       start;
        logic       pause;
        logic       stop;
        logic       mag;
        logic       lamp;
        logic       bp;
    } exp_t;

    exp_t sb_q[$];

    microwave_ctrl #(.BEEP_CYCLES(8), .QUICK_SEC(30)) dut (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .door_open(door_open), .timer_done(timer_done), .tmr_min(tmr_min),
        .tmr_sec(tmr_sec), .tmr_start(tmr_start), .tmr_pause(tmr_pause),
        .tmr_stop(tmr_stop), .magnetron_on(magnetron_on), .lamp_on(lamp_on),
        .beep(beep), .state(state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st, input logic [6:0] mn, input logic [6:0] sc,
                                input logic start, input logic pause, input logic stop,
                                input logic mag, input logic lamp, input logic bp);
        exp_t e;
        e = {st, mn, sc, start, pause, stop, mag, lamp, bp};
        return e;
    endfunction

    task automatic step(input string tag, input logic kv, input logic [3:0] kc,
                        input logic dr, input logic td, input exp_t e);
        exp_t x;
        @(negedge clock);
        key_valid  = kv;
        key_code   = kc;
        door_open  = dr;
        timer_done = td;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        key_valid  = 1'b0;
        timer_done = 1'b0;
        check($sformatf("%s.sb_size", tag), sb_q.size(), 1);
        x = sb_q.pop_front();
        check($sformatf("%s.state", tag), state, x.st);
        check($sformatf("%s.min", tag), tmr_min, x.mn);
        check($sformatf("%s.sec", tag), tmr_sec, x.sc);
        check($sformatf("%s.start", tag), tmr_start, x.start);
        check($sformatf("%s.pause", tag), tmr_pause, x.pause);
        check($sformatf("%s.stop", tag), tmr_stop, x.stop);
        check($sformatf("%s.mag", tag), magnetron_on, x.mag);
        check($sformatf("%s.lamp", tag), lamp_on, x.lamp);
        check($sformatf("%s.beep", tag), beep, x.bp);
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s.state", tag), state, 0);
        check($sformatf("%s.min", tag), tmr_min, 0);
        check($sformatf("%s.sec", tag), tmr_sec, 0);
        check($sformatf("%s.pulses", tag), {tmr_start, tmr_pause, tmr_stop}, 0);
        check($sformatf("%s.mag", tag), magnetron_on, 0);
        check($sformatf("%s.lamp", tag), lamp_on, 0);
        check($sformatf("%s.beep", tag), beep, 0);
    endtask

    initial begin
        reset      = 1'b0;
        key_valid  = 1'b0;
        key_code   = 4'h0;
        door_open  = 1'b0;
        timer_done = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b1;

        // 12:34 entry and start
        step("k1", 1'b1, 4'd1, 1'b0, 1'b0, mk(3'd1, 7'd0, 7'd1, 0, 0, 0, 0, 0, 0));
        step("k2", 1'b1, 4'd2, 1'b0, 1'b0, mk(3'd1, 7'd0, 7'd12, 0, 0, 0, 0, 0, 0));
        step("k3", 1'b1, 4'd3, 1'b0, 1'b0, mk(3'd1, 7'd1, 7'd23, 0, 0, 0, 0, 0, 0));
        step("k4", 1'b1, 4'd4, 1'b0, 1'b0, mk(3'd1, 7'd12, 7'd34, 0, 0, 0, 0, 0, 0));
        step("start", 1'b1, 4'hA, 1'b0, 1'b0, mk(3'd2, 7'd12, 7'd34, 1, 0, 0, 1, 1, 0));
        step("cook", 1'b0, 4'h0, 1'b0, 1'b0, mk(3'd2, 7'd12, 7'd34, 0, 0, 0, 1, 1, 0));
        step("cook_dig", 1'b1, 4'd5, 1'b0, 1'b0, mk(3'd2, 7'd12, 7'd34, 0, 0, 0, 1, 1, 0));
        step("cook_clr", 1'b1, 4'hC, 1'b0, 1'b0, mk(3'd0, 7'd0, 7'd0, 0, 0, 1, 0, 0, 0));
        step("idle", 1'b0, 4'h0, 1'b0, 1'b0, mk(3'd0, 7'd0, 7'd0, 0, 0, 0, 0, 0, 0));

        // Seconds clipping and M1 discard
        step("e1", 1'b1, 4'd1, 1'b0, 1'b0, mk(3'd1, 7'd0, 7'd1, 0, 0, 0, 0, 0, 0));
        step("e9a", 1'b1, 4'd9, 1'b0, 1'b0, mk(3'd1, 7'd0, 7'd19, 0, 0, 0, 0, 0, 0));
        step("e9b", 1'b1, 4'd9, 1'b0, 1'b0, mk(3'd1, 7'd1, 7'd59, 0, 0, 0, 0, 0, 0));
        step("e5", 1'b1, 4'd5, 1'b0, 1'b0, mk(3'd1, 7'd19, 7'd59, 0, 0, 0, 0, 0, 0));
        step("e6", 1'b1, 4'd6, 1'b0, 1'b0, mk(3'd1, 7'd99, 7'd56, 0, 0, 0, 0, 0, 0));
        step("e7", 1'b1, 4'd7, 1'b0, 1'b0, mk(3'd1, 7'd95, 7'd59, 0, 0, 0, 0, 0, 0));
        step("e8", 1'b1, 4'd8, 1'b0, 1'b0, mk(3'd1, 7'd56, 7'd59, 0, 0, 0, 0, 0, 0));
        step("e9c", 1'b1, 4'd9, 1'b0, 1'b0, mk(3'd1, 7'd67, 7'd59, 0, 0, 0, 0, 0, 0));
        step("e_clr", 1'b1, 4'hC, 1'b0, 1'b0, mk(3'd0, 7'd0, 7'd0, 0, 0, 0, 0, 0, 0));

        // Quick start, door pause, resume, PAUSE key
        step("quick", 1'b1, 4'hA, 1'b0, 1'b0, mk(3'd2, 7'd0, 7'd30, 1, 0, 0, 1, 1, 0));
        step("q_cook", 1'b0, 4'h0, 1'b0, 1'b0, mk(3'd2, 7'd0, 7'd30, 0, 0, 0, 1, 1, 0));
        step("door_up", 1'b0, 4'h0, 1'b1, 1'b0, mk(3'd3, 7'd0, 7'd30, 0, 1, 0, 0, 1, 0));
        step("door_held", 1'b0, 4'h0, 1'b1, 1'b0, mk(3'd3, 7'd0, 7'd30, 0, 0, 0, 0, 1, 0));
        step("start_open", 1'b1, 4'hA, 1'b1, 1'b0, mk(3'd3, 7'd0, 7'd30, 0, 0, 0, 0, 1, 0));
        step("door_shut", 1'b0, 4'h0, 1'b0, 1'b0, mk(3'd3, 7'd0, 7'd30, 0, 0, 0, 0, 1, 0));
        step("resume", 1'b1, 4'hA, 1'b0, 1'b0, mk(3'd2, 7'd0, 7'd30, 1, 0, 0, 1, 1, 0));
        step("pause_key", 1'b1, 4'hB, 1'b0, 1'b0, mk(3'd3, 7'd0, 7'd30, 0, 1, 0, 0, 1, 0));
        step("pause_again", 1'b1, 4'hB, 1'b0, 1'b0, mk(3'd3, 7'd0, 7'd30, 0, 0, 0, 0, 1, 0));
        step("p_done_ign", 1'b0, 4'h0, 1'b0, 1'b1, mk(3'd3, 7'd0, 7'd30, 0, 0, 0, 0, 1, 0));
        step("resume2", 1'b1, 4'hA, 1'b0, 1'b0, mk(3'd2, 7'd0, 7'd30, 1, 0, 0, 1, 1, 0));

        // Completion: beep for exactly 8 cycles then IDLE with cleared buffer
        step("done", 1'b0, 4'h0, 1'b0, 1'b1, mk(3'd4, 7'd0, 7'd30, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 7; i++)
            step($sformatf("beep%0d", i), 1'b0, 4'h0, 1'b0, 1'b0, mk(3'd4, 7'd0, 7'd30, 0, 0, 0, 0, 0, 1));
        step("beep_end", 1'b0, 4'h0, 1'b0, 1'b0, mk(3'd0, 7'd0, 7'd0, 0, 0, 0, 0, 0, 0));

        // Quick start refused with door open
        step("q_open", 1'b1, 4'hA, 1'b1, 1'b0, mk(3'd0, 7'd0, 7'd0, 0, 0, 0, 0, 1, 0));
        step("q_shut", 1'b0, 4'h0, 1'b0, 1'b0, mk(3'd0, 7'd0, 7'd0, 0, 0, 0, 0, 0, 0));

        // timer_done beats door_open; key in DONE aborts and is discarded
        step("k5", 1'b1, 4'd5, 1'b0, 1'b0, mk(3'd1, 7'd0, 7'd5, 0, 0, 0, 0, 0, 0));
        step("start5", 1'b1, 4'hA, 1'b0, 1'b0, mk(3'd2, 7'd0, 7'd5, 1, 0, 0, 1, 1, 0));
        step("done_door", 1'b0, 4'h0, 1'b1, 1'b1, mk(3'd4, 7'd0, 7'd5, 0, 0, 0, 0, 1, 1));
        step("done_key", 1'b1, 4'd7, 1'b0, 1'b0, mk(3'd0, 7'd0, 7'd0, 0, 0, 0, 0, 0, 0));

        // START with an all-zero entry is ignored
        step("k0", 1'b1, 4'd0, 1'b0, 1'b0, mk(3'd1, 7'd0, 7'd0, 0, 0, 0, 0, 0, 0));
        step("start_zero", 1'b1, 4'hA, 1'b0, 1'b0, mk(3'd1, 7'd0, 7'd0, 0, 0, 0, 0, 0, 0));
        step("zero_clr", 1'b1, 4'hC, 1'b0, 1'b0, mk(3'd0, 7'd0, 7'd0, 0, 0, 0, 0, 0, 0));

        // Asynchronous reset in the middle of cooking
        step("q2", 1'b1, 4'hA, 1'b0, 1'b0, mk(3'd2, 7'd0, 7'd30, 1, 0, 0, 1, 1, 0));
        step("q2_cook", 1'b0, 4'h0, 1'b0, 1'b0, mk(3'd2, 7'd0, 7'd30, 0, 0, 0, 1, 1, 0));
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clock);
        reset = 1'b1;
        step("post_rst", 1'b0, 4'h0, 1'b0, 1'b0, mk(3'd0, 7'd0, 7'd0, 0, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/microwave_ctrl.md
Name: microwave_ctrl

Overview:
- Top-level sequencer for the microwave oven; sits between keypad/door inputs and the countdown timer.
- Collects a 4-digit MM:SS cook time from the keypad and presents it to the timer as binary minutes/seconds.
- Issues one-cycle start/pause/stop pulses to the timer and drives magnetron, lamp and end-of-cook beeper.
- Enforces a door interlock: the magnetron is never on while the door is open.

Parameters:
BEEP_CYCLES, 100_000_000, clock cycles beeper stays on after cook completion (1 s at 100 MHz)
QUICK_SEC, 30, seconds loaded by quick-start (START with empty entry)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets)
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  0-9 digit; 4'hA START; 4'hB PAUSE; 4'hC CLEAR; 4'hD-4'hF ignored
door_open  in  1  level, 1 = door open (synchronised upstream)
timer_done  in  1  level/pulse from timer, 1 = countdown reached 00:00
tmr_min  out  7  minutes to timer, 0-99
tmr_sec  out  7  seconds to timer, 0-59
tmr_start  out  1  one-cycle pulse: load/resume timer
tmr_pause  out  1  one-cycle pulse: freeze timer
tmr_stop  out  1  one-cycle pulse: abort timer
magnetron_on  out  1  heating enable
lamp_on  out  1  cavity lamp
beep  out  1  beeper enable
state  out  3  current state code for the display

Behaviour:
- Reset (reset=0, async): state=IDLE, digit buffer=0000, all outputs 0.
- State codes: IDLE=0, ENTRY=1, COOK=2, PAUSED=3, DONE=4; encodings 5-7 recover to IDLE on the next clock.
- Digit buffer: 4 BCD digits M1 M0 S1 S0; each digit key shifts left, new digit enters S0, old M1 discarded.
- tmr_min = M1*10+M0 (0-99); tmr_sec = min(S1*10+S0, 59). Both are registered and combinationally derived from the buffer. They are held constant while in COOK/PAUSED.
- All outputs are registered. Pulses appear exactly one cycle after the sampling edge of the triggering input and last one cycle.
- magnetron_on = (state==COOK). lamp_on = (state==COOK or PAUSED or door_open). beep = (state==DONE).
- Event priority within a cycle: CLEAR key > timer_done > door_open > START/PAUSE key.
- IDLE:
  - digit: buffer <= {000,digit}, go to ENTRY.
  - START with door closed: buffer <= QUICK_SEC as 00:SS, tmr_start, go to COOK.
  - START with door open: ignored. PAUSE/CLEAR: no action.
- ENTRY:
  - digit: shift.
  - CLEAR: buffer=0, go to IDLE.
  - START, door closed, buffer≠0: tmr_start, go to COOK.
  - START with door open or buffer=0: ignored.
- COOK:
  - CLEAR: tmr_stop, buffer=0, go to IDLE.
  - timer_done: go to DONE.
  - door_open=1 (level): tmr_pause, go to PAUSED; magnetron_on drops on the same edge the state leaves COOK.
  - PAUSE: tmr_pause, go to PAUSED.
  - Digits and START are ignored.
- PAUSED:
  - START with door closed: tmr_start, go to COOK.
  - CLEAR: tmr_stop, buffer=0, go to IDLE.
  - PAUSE: ignored (no toggle). Digits: ignored.
  - timer_done: ignored.
- DONE:
  - Beep counter runs 0..BEEP_CYCLES-1, then buffer=0 and go to IDLE. beep is high for exactly BEEP_CYCLES cycles.
  - Any key: go to IDLE immediately, buffer=0, key discarded.
- Beep counter: 27 bits, cleared on entry to DONE and on reset.
- Reset mid-COOK: magnetron_on falls asynchronously. No tmr_stop pulse is issued; the timer shares the reset.

Test Plan:
- Keys 1,2,3,4 then START (door closed) -> state ENTRY after the first key; tmr_min=12, tmr_sec=34; tmr_start high exactly 1 cycle after START; magnetron_on=1, state=2.
- Keys 1,9,9 -> buffer 0199, tmr_min=1, tmr_sec=59; keys 5,6,7,8,9 -> buffer 6789, tmr_min=67, tmr_sec=59.
- START in IDLE with door closed -> tmr_min=0, tmr_sec=30, tmr_start pulse, COOK. Repeat with door_open=1 -> stays IDLE, no pulse.
- In COOK raise door_open -> next cycle magnetron_on=0, tmr_pause one pulse, state=3, lamp_on=1. Close door and press START -> tmr_start pulse, COOK. Press PAUSE in PAUSED -> no change.
- BEEP_CYCLES=8, assert timer_done in COOK -> state=4, beep high exactly 8 cycles, then IDLE with buffer 0. Same cycle timer_done+door_open -> DONE, no tmr_pause.
- Pull reset low mid-COOK asynchronously -> all outputs 0 before the next clock edge. After release, state=0. CLEAR during COOK -> tmr_stop pulse, IDLE.
